fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, width of PC and instruction fields.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1, fetch stage offers an instruction.
REQ-006 SHALL have port in_pc, input, XLEN, PC of offered instruction.
REQ-007 SHALL have port in_instr, input, XLEN, offered instruction word.
REQ-008 SHALL have port in_ready, output, 1, queue accepts a push this cycle.
REQ-009 SHALL have port out_valid, output, 1, head entry available to decode.
REQ-010 SHALL have port out_pc, output, XLEN, PC of head entry.
REQ-011 SHALL have port out_instr, output, XLEN, instruction of head entry.
REQ-012 SHALL have port out_ready, input, 1, decode consumes head (deasserted on decode stall).
REQ-013 SHALL have port flush, input, 1, branch/jump taken in EX; discard all entries.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-015 SHALL push when in_valid && in_ready && !flush; entry written at write pointer.
REQ-016 SHALL pop when out_valid && out_ready && !flush; read pointer advances by one.
REQ-017 SHALL drive in_ready = (count != DEPTH); no push-through when full, even with simultaneous pop.
REQ-018 SHALL drive out_valid = (count != 0) (bypass case per REQ-029).
REQ-019 SHALL present out_pc/out_instr from the head entry; hold stable while out_valid && !out_ready.
REQ-020 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-021 SHALL wrap read/write pointers modulo DEPTH with no bubble at wrap-around.
REQ-022 SHALL, on flush, set count=0 and equal pointers at the next edge; push and pop in that cycle are discarded.
REQ-023 SHALL accept a new push in the cycle immediately after flush.
REQ-024 SHALL, without bypass, have push-to-out_valid latency of exactly 1 cycle when empty.
REQ-025 SHALL never overflow or underflow; push when full and pop when empty are ignored.
REQ-026 SHALL preserve strict FIFO order of (pc, instr) pairs.

Reset
REQ-027 SHALL, on reset low, asynchronously force count=0, pointers=0, out_valid=0, in_ready=1.
REQ-028 SHALL discard all entries if reset asserts mid-operation; out_pc/out_instr are don't-care while out_valid=0.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, pass in_pc/in_instr combinationally to outputs with out_valid=1 when count==0 && in_valid && !flush; if out_ready also set, nothing is stored and count stays 0.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, have no in-to-out combinational path (latency per REQ-024).

Verification
REQ-031 SHALL cover: DEPTH=4, push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0; 5th push 0x10 dropped.
REQ-032 SHALL cover: full queue, then out_ready=1 for 4 cycles -> outputs pc 0x00,0x04,0x08,0x0C in order, count=0, out_valid=0.
REQ-033 SHALL cover: continuous push/pop for 10 cycles (pc 0x100 step 4) -> count constant, order preserved across pointer wrap.
REQ-034 SHALL cover: count=3 with flush=1 and in_valid=1 (pc 0x200) -> next cycle count=0, out_valid=0, 0x200 not stored.
REQ-035 SHALL cover: reset low mid-traffic with count=2 -> immediately count=0, out_valid=0; after release push 0x300 appears after 1 cycle (0 cycles with FETCH_QUEUE_BYPASS_EN).

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch-side push, decode-side pop, flush, occupancy.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            in_valid;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_instr;
   logic            in_ready;
   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic            out_ready;
   logic            flush;
   logic [CW-1:0]   count;

   modport master (
      output in_valid,
      output in_pc,
      output in_instr,
      output out_ready,
      output flush,
      input  in_ready,
      input  out_valid,
      input  out_pc,
      input  out_instr,
      input  count
   );

   modport slave (
      input  in_valid,
      input  in_pc,
      input  in_instr,
      input  out_ready,
      input  flush,
      output in_ready,
      output out_valid,
      output out_pc,
      output out_instr,
      output count
   );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush support.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.slave  fq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic full;
   logic empty;
   logic byp;
   logic push;
   logic pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = empty && fq.in_valid && !fq.flush;
`else
   assign byp = 1'b0;
`endif

   // A bypassed entry taken by decode the same cycle is never stored.
   assign push = fq.in_valid && !full && !fq.flush
                 && !(byp && fq.out_ready);
   assign pop  = !empty && fq.out_ready && !fq.flush;

   assign fq.in_ready  = !full;
   assign fq.out_valid = !empty || byp;
   assign fq.out_pc    = byp ? fq.in_pc    : pc_mem_q[rd_ptr_q];
   assign fq.out_instr = byp ? fq.in_instr : instr_mem_q[rd_ptr_q];
   assign fq.count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (fq.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only visible while out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fq.in_pc;
         instr_mem_q[wr_ptr_q] <= fq.in_instr;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
// Checks use immediate assertions; one summary line at the end.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      fq.in_valid  = 1'b0;
      fq.in_pc     = '0;
      fq.in_instr  = '0;
      fq.out_ready = 1'b0;
      fq.flush     = 1'b0;
      #2;
      check("rst_count", 64'(fq.count), 64'd0);
      check("rst_oval", 64'(fq.out_valid), 64'd0);
      check("rst_irdy", 64'(fq.in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Fill with decode stalled
      fq.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fq.in_pc    = 32'(i * 4);
         fq.in_instr = 32'hA000 + 32'(i);
         tick();
      end
      check("fill_count", 64'(fq.count), 64'd4);
      check("fill_irdy", 64'(fq.in_ready), 64'd0);
      check("fill_oval", 64'(fq.out_valid), 64'd1);
      fq.in_pc    = 32'h10;
      fq.in_instr = 32'hA004;
      tick();
      check("ovf_count", 64'(fq.count), 64'd4);
      check("hold_pc", 64'(fq.out_pc), 64'h0);
      check("hold_instr", 64'(fq.out_instr), 64'hA000);

      // Drain in order
      fq.in_valid  = 1'b0;
      fq.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 64'(fq.out_pc), 64'(i * 4));
         check("drain_instr", 64'(fq.out_instr), 64'hA000 + 64'(i));
         tick();
      end
      check("drain_count", 64'(fq.count), 64'd0);
      check("drain_oval", 64'(fq.out_valid), 64'd0);
      tick();
      check("udf_count", 64'(fq.count), 64'd0);

      // Streaming push/pop across pointer wrap
      fq.out_ready = 1'b0;
      fq.in_valid  = 1'b1;
      fq.in_pc     = 32'h100;
      fq.in_instr  = 32'hB100;
      tick();
      check("stream_pre", 64'(fq.count), 64'd1);
      fq.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         fq.in_pc    = 32'h104 + 32'(4 * k);
         fq.in_instr = 32'hB104 + 32'(4 * k);
         #1;
         check("stream_pc", 64'(fq.out_pc), 64'h100 + 64'(4 * k));
         check("stream_instr", 64'(fq.out_instr), 64'hB100 + 64'(4 * k));
         tick();
         check("stream_count", 64'(fq.count), 64'd1);
      end
      fq.in_valid = 1'b0;
      tick();
      check("stream_end", 64'(fq.count), 64'd0);

      // Flush with simultaneous push
      fq.out_ready = 1'b0;
      fq.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fq.in_pc    = 32'h180 + 32'(4 * i);
         fq.in_instr = 32'hC000 + 32'(i);
         tick();
      end
      check("pre_flush", 64'(fq.count), 64'd3);
      fq.flush    = 1'b1;
      fq.in_pc    = 32'h200;
      fq.in_instr = 32'hD200;
      tick();
      fq.flush    = 1'b0;
      fq.in_valid = 1'b0;
      #1;
      check("flush_count", 64'(fq.count), 64'd0);
      check("flush_oval", 64'(fq.out_valid), 64'd0);
      fq.in_valid = 1'b1;
      fq.in_pc    = 32'h204;
      fq.in_instr = 32'hD204;
      tick();
      fq.in_valid = 1'b0;
      check("post_flush_cnt", 64'(fq.count), 64'd1);
      check("post_flush_pc", 64'(fq.out_pc), 64'h204);
      fq.out_ready = 1'b1;
      tick();
      fq.out_ready = 1'b0;
      check("post_flush_pop", 64'(fq.count), 64'd0);

      // Reset mid-traffic
      fq.in_valid = 1'b1;
      fq.in_pc    = 32'h280;
      fq.in_instr = 32'hE280;
      tick();
      fq.in_pc    = 32'h284;
      fq.in_instr = 32'hE284;
      tick();
      fq.in_valid = 1'b0;
      check("pre_rst_cnt", 64'(fq.count), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_cnt", 64'(fq.count), 64'd0);
      check("mid_rst_oval", 64'(fq.out_valid), 64'd0);
      check("mid_rst_irdy", 64'(fq.in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      fq.in_valid = 1'b1;
      fq.in_pc    = 32'h300;
      fq.in_instr = 32'hF300;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("rel_oval_now", 64'(fq.out_valid), 64'd1);
      check("rel_pc_now", 64'(fq.out_pc), 64'h300);
`else
      check("rel_oval_now", 64'(fq.out_valid), 64'd0);
`endif
      tick();
      fq.in_valid = 1'b0;
      #1;
      check("rel_oval", 64'(fq.out_valid), 64'd1);
      check("rel_pc", 64'(fq.out_pc), 64'h300);
      check("rel_instr", 64'(fq.out_instr), 64'hF300);
      check("rel_count", 64'(fq.count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
